dec_scan_seq: RTL and testbench

DEC_SCAN_SEQ -- requirements
Module: dec_scan_seq

---
 rtl/dec_pkg.sv | 31 +++
 rtl/dec_onehot.sv | 18 +
 rtl/dec_scan_seq.sv | 115 +++++++++++
 tb/tb_dec_scan_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared encodings for the scanning decoder: operating modes, FSM states and
// the mapping from a requested mode to the FSM state that serves it.
package dec_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT  = 2'b00,
        MODE_SCAN_UP = 2'b01,
        MODE_SCAN_DN = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DIRECT = 2'b01,
        ST_SCAN   = 2'b10,
        ST_HOLD   = 2'b11
    } state_e;

    // Both scan directions share one state; the direction comes from the latched mode.
    function automatic state_e state_for_mode(input mode_e m);
        state_e s;
        case (m)
            MODE_DIRECT:  s = ST_DIRECT;
            MODE_SCAN_UP: s = ST_SCAN;
            MODE_SCAN_DN: s = ST_SCAN;
            default:      s = ST_HOLD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational binary-to-one-hot decoder with an enable that forces all-zero.
module dec_onehot #(
    parameter  int SEL_W = 4,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic [SEL_W-1:0] code_i,
    input  logic             en_i,
    output logic [OUT_W-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[code_i] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_scan_seq.sv
// Code register with direct load, prescaled up/down scanning and hold, driving a
// registered one-hot decoder output with valid and wrap indications.
module dec_scan_seq
    import dec_pkg::*;
#(
    parameter  int SEL_W = 4,
    parameter  int DIV_W = 8,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [SEL_W-1:0] sel,
    input  logic [DIV_W-1:0] div,
    output logic [OUT_W-1:0] decoded,
    output logic [SEL_W-1:0] code_q,
    output logic             valid,
    output logic             wrap
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    mode_e              modeIn;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic [SEL_W-1:0]   code_d;
    logic               wrap_q, wrap_d;
    logic [OUT_W-1:0]   decoded_q;
    logic [OUT_W-1:0]   onehotNext;
    logic               valid_q;

    assign modeIn = mode_e'(mode);

    // Decoder sees the current code; its result is registered, so decoded trails code_q by one edge.
    dec_onehot #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .code_i   (code_q),
        .en_i     (en),
        .onehot_o (onehotNext)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        code_d  = code_q;
        wrap_d  = 1'b0;

        if (state_q == ST_IDLE) begin
            state_d = state_for_mode(modeIn);
            mode_d  = modeIn;
            presc_d = '0;
        end else if (modeIn != mode_q) begin
            state_d = state_for_mode(modeIn);
            mode_d  = modeIn;
            presc_d = '0;
            if (load) begin
                code_d = sel;
            end
        end else begin
            case (state_q)
                ST_SCAN: begin
                    // A load beats a coinciding step and restarts the period from zero.
                    if (load) begin
                        code_d  = sel;
                        presc_d = '0;
                    end else if (presc_q == div) begin
                        presc_d = '0;
                        if (mode_q == MODE_SCAN_UP) begin
                            code_d = code_q + 1'b1;
                            wrap_d = (code_q == {SEL_W{1'b1}});
                        end else begin
                            code_d = code_q - 1'b1;
                            wrap_d = (code_q == '0);
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: begin
                    if (load) begin
                        code_d = sel;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_DIRECT;
            presc_q   <= '0;
            code_q    <= '0;
            wrap_q    <= 1'b0;
            decoded_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            code_q    <= code_d;
            wrap_q    <= wrap_d;
            decoded_q <= onehotNext;
            valid_q   <= en;
        end
    end

    assign decoded = decoded_q;
    assign valid   = valid_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Bench for dec_scan_seq: three widths run in lockstep against a cycle-level
// reference model built from the behavioural rules, plus directed spot checks.
module tb_dec_scan_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [1:0] mode;
    logic [5:0] sel;
    logic [7:0] div;

    logic [3:0]  dec2;
    logic [1:0]  code2;
    logic        valid2, wrap2;
    logic [15:0] dec4;
    logic [3:0]  code4;
    logic        valid4, wrap4;
    logic [63:0] dec6;
    logic [5:0]  code6;
    logic        valid6, wrap6;

    int nCompared = 0;
    int nMismatch = 0;

    // Reference model state: one code per width, shared period counter and mode.
    int          widths [3] = '{2, 4, 6};
    int          mCode  [3];
    bit          mWrap  [3];
    logic [63:0] mDec   [3];
    bit          mValid;
    bit          mStarted;
    int          mMode;
    int          mCount;

    always #5 clk = ~clk;

    dec_scan_seq #(.SEL_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .sel(sel[1:0]), .div(div), .decoded(dec2), .code_q(code2),
        .valid(valid2), .wrap(wrap2)
    );

    dec_scan_seq #(.SEL_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .sel(sel[3:0]), .div(div), .decoded(dec4), .code_q(code4),
        .valid(valid4), .wrap(wrap4)
    );

    dec_scan_seq #(.SEL_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .sel(sel), .div(div), .decoded(dec6), .code_q(code6),
        .valid(valid6), .wrap(wrap6)
    );

    task automatic modelReset();
        mStarted = 1'b0;
        mMode    = 0;
        mCount   = 0;
        mValid   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mCode[i] = 0;
            mWrap[i] = 1'b0;
            mDec[i]  = '0;
        end
    endtask

    task automatic modelLoad();
        for (int i = 0; i < 3; i++) mCode[i] = int'(sel) % (1 << widths[i]);
    endtask

    // Predict what one rising edge does given the inputs currently applied.
    task automatic advanceModel();
        int size;
        if (!rst_n) begin
            modelReset();
            return;
        end
        mValid = en;
        for (int i = 0; i < 3; i++) begin
            mDec[i]  = en ? (64'd1 << mCode[i]) : 64'd0;
            mWrap[i] = 1'b0;
        end
        if (!mStarted) begin
            mStarted = 1'b1;
            mMode    = int'(mode);
            mCount   = 0;
        end else if (int'(mode) != mMode) begin
            mMode  = int'(mode);
            mCount = 0;
            if (load) modelLoad();
        end else if (mMode == 1 || mMode == 2) begin
            if (load) begin
                modelLoad();
                mCount = 0;
            end else if (mCount == int'(div)) begin
                mCount = 0;
                for (int i = 0; i < 3; i++) begin
                    size = 1 << widths[i];
                    if (mMode == 1) begin
                        mWrap[i] = (mCode[i] == size - 1);
                        mCode[i] = (mCode[i] + 1) % size;
                    end else begin
                        mWrap[i] = (mCode[i] == 0);
                        mCode[i] = (mCode[i] + size - 1) % size;
                    end
                end
            end else begin
                mCount = (mCount + 1) % 256;
            end
        end else if (load) begin
            modelLoad();
        end
    endtask

    task automatic compare(input string name, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, " code2"},  64'(code2),  64'(mCode[0]));
        compare({tag, " dec2"},   64'(dec2),   mDec[0]);
        compare({tag, " wrap2"},  64'(wrap2),  64'(mWrap[0]));
        compare({tag, " valid2"}, 64'(valid2), 64'(mValid));
        compare({tag, " code4"},  64'(code4),  64'(mCode[1]));
        compare({tag, " dec4"},   64'(dec4),   mDec[1]);
        compare({tag, " wrap4"},  64'(wrap4),  64'(mWrap[1]));
        compare({tag, " valid4"}, 64'(valid4), 64'(mValid));
        compare({tag, " code6"},  64'(code6),  64'(mCode[2]));
        compare({tag, " dec6"},   dec6,        mDec[2]);
        compare({tag, " wrap6"},  64'(wrap6),  64'(mWrap[2]));
        compare({tag, " valid6"}, 64'(valid6), 64'(mValid));
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic e, input logic l,
                                 input logic [5:0] s, input logic [7:0] d);
        mode = m;
        en   = e;
        load = l;
        sel  = s;
        div  = d;
    endtask

    task automatic cycle(input string tag);
        advanceModel();
        @(posedge clk);
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        applyStimulus(2'b01, 1'b1, 1'b0, 6'd0, 8'd0);
        modelReset();
        #1 checkOutput("reset");
        cycle("reset");
        cycle("reset");

        // Release with SCAN_UP, div=0: first edge leaves IDLE, then one step per edge.
        rst_n = 1'b1;
        cycle("rel1");
        compare("rel1 code4 const", 64'(code4), 64'd0);
        cycle("rel2");
        compare("rel2 code4 const", 64'(code4), 64'd1);
        for (int i = 0; i < 4; i++) cycle("scanup0");

        // Asynchronous reset mid-scan, between clock edges.
        applyStimulus(2'b01, 1'b1, 1'b0, 6'd0, 8'd1);
        cycle("prerst");
        advanceModel();
        @(posedge clk);
        #2 rst_n = 1'b0;
        modelReset();
        #1 checkOutput("midrst");
        compare("midrst dec4 const", 64'(dec4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle("restart");

        // DIRECT load of 0xA.
        applyStimulus(2'b00, 1'b1, 1'b0, 6'd0, 8'd0);
        cycle("direct");
        applyStimulus(2'b00, 1'b1, 1'b1, 6'hA, 8'd0);
        cycle("dload");
        compare("dload code4 const", 64'(code4), 64'hA);
        applyStimulus(2'b00, 1'b1, 1'b0, 6'h0, 8'd0);
        cycle("dlat");
        compare("dlat dec4 const", 64'(dec4), 64'h0400);
        compare("dlat valid4 const", 64'(valid4), 64'd1);

        // SCAN_UP from 14 with div=2 crosses the top of the 4-bit range.
        applyStimulus(2'b00, 1'b1, 1'b1, 6'd14, 8'd0);
        cycle("ld14");
        applyStimulus(2'b01, 1'b1, 1'b0, 6'd0, 8'd2);
        for (int i = 0; i < 12; i++) cycle("wrapup");

        // SCAN_DN with outputs masked for three cycles.
        applyStimulus(2'b10, 1'b0, 1'b0, 6'd0, 8'd0);
        for (int i = 0; i < 3; i++) cycle("dn_masked");
        applyStimulus(2'b10, 1'b1, 1'b0, 6'd0, 8'd0);
        for (int i = 0; i < 5; i++) cycle("dn_en");

        // Load landing on the terminal count of the prescaler.
        applyStimulus(2'b01, 1'b1, 1'b0, 6'd0, 8'd3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mMode == 1 && mCount == 3) found = 1'b1;
            else cycle("collide_wait");
        end
        compare("collide terminal reached", 64'(found), 64'd1);
        applyStimulus(2'b01, 1'b1, 1'b1, 6'd5, 8'd3);
        cycle("collide");
        compare("collide code4 const", 64'(code4), 64'd5);
        compare("collide wrap4 const", 64'(wrap4), 64'd0);
        applyStimulus(2'b01, 1'b1, 1'b0, 6'd0, 8'd3);
        for (int i = 0; i < 3; i++) cycle("collide_hold");
        compare("collide no early step", 64'(code4), 64'd5);
        cycle("collide_step");
        compare("collide step const", 64'(code4), 64'd6);

        // HOLD freezes the code but honours loads.
        applyStimulus(2'b11, 1'b1, 1'b0, 6'd0, 8'd0);
        for (int i = 0; i < 3; i++) cycle("hold");
        applyStimulus(2'b11, 1'b1, 1'b1, 6'($urandom), 8'd0);
        cycle("hold_ld");
        applyStimulus(2'b11, 1'b1, 1'b0, 6'd0, 8'd0);
        for (int i = 0; i < 3; i++) cycle("hold");

        // Randomized traffic: rare mode changes, random enable/load/sel/div.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0) ? 2'($urandom) : mode,
                          1'($urandom), ($urandom_range(0, 7) == 0),
                          6'($urandom), 8'($urandom_range(0, 3)));
            cycle("random");
        end

        // Full-range sweeps up and down cover 3->0, 15->0 and 63->0.
        applyStimulus(2'b01, 1'b1, 1'b0, 6'd0, 8'd0);
        for (int i = 0; i < 70; i++) cycle("sweep_up");
        applyStimulus(2'b10, 1'b1, 1'b0, 6'd0, 8'd0);
        for (int i = 0; i < 70; i++) cycle("sweep_dn");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
